// File: rtl/decode_stage.sv
// Registered RV32I decoder feeding the ALU operand/control interface, one pipeline register deep.
// Optional DECODE_ILLEGAL_CHECK_EN adds opcode/funct7 legality checking and drives illegal_o.

package pkg_config;
  parameter int DATA_WIDTH = 32;

  localparam logic [5:0] OP_ALU_ADD  = 6'd0;
  localparam logic [5:0] OP_ALU_SUB  = 6'd1;
  localparam logic [5:0] OP_ALU_SLL  = 6'd2;
  localparam logic [5:0] OP_ALU_SLT  = 6'd3;
  localparam logic [5:0] OP_ALU_SLTU = 6'd4;
  localparam logic [5:0] OP_ALU_XOR  = 6'd5;
  localparam logic [5:0] OP_ALU_SRL  = 6'd6;
  localparam logic [5:0] OP_ALU_SRA  = 6'd7;
  localparam logic [5:0] OP_ALU_OR   = 6'd8;
  localparam logic [5:0] OP_ALU_AND  = 6'd9;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
endpackage

module decode_stage #(
  parameter int DATA_WIDTH = pkg_config::DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [31:0]           instr_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  flush_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [5:0]            alu_op_o,
  output logic [1:0]            a_sel_o,
  output logic                  b_sel_o,
  output logic [DATA_WIDTH-1:0] imm_o,
  output logic [4:0]            rs1_addr_o,
  output logic [4:0]            rs2_addr_o,
  output logic [4:0]            rd_addr_o,
  output logic                  rd_we_o,
  output logic                  is_alu_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic       alt;

  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] imm_u;

  logic [5:0]            d_alu_op;
  logic [1:0]            d_a_sel;
  logic                  d_b_sel;
  logic [31:0]           d_imm32;
  logic [DATA_WIDTH-1:0] d_imm;
  logic                  d_rd_we;
  logic                  d_is_alu;
  logic                  d_illegal;

  logic accept;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign rd     = instr_i[11:7];
  assign alt    = instr_i[30];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};

  // alt selects SUB (funct3 000) or SRA (funct3 101); callers mask it where it has no meaning.
  function automatic logic [5:0] alu_from_funct3(input logic [2:0] f3, input logic sel_alt);
    logic [5:0] op;
    case (f3)
      3'b000:  op = sel_alt ? pkg_config::OP_ALU_SUB : pkg_config::OP_ALU_ADD;
      3'b001:  op = pkg_config::OP_ALU_SLL;
      3'b010:  op = pkg_config::OP_ALU_SLT;
      3'b011:  op = pkg_config::OP_ALU_SLTU;
      3'b100:  op = pkg_config::OP_ALU_XOR;
      3'b101:  op = sel_alt ? pkg_config::OP_ALU_SRA : pkg_config::OP_ALU_SRL;
      3'b110:  op = pkg_config::OP_ALU_OR;
      default: op = pkg_config::OP_ALU_AND;
    endcase
    return op;
  endfunction

`ifdef DECODE_ILLEGAL_CHECK_EN
  logic       opc_known;
  logic [6:0] funct7;

  assign funct7 = instr_i[31:25];

  always_comb begin
    opc_known = 1'b0;
    case (opcode)
      pkg_config::OPC_LOAD, pkg_config::OPC_FENCE, pkg_config::OPC_OP_IMM,
      pkg_config::OPC_AUIPC, pkg_config::OPC_STORE, pkg_config::OPC_OP,
      pkg_config::OPC_LUI, pkg_config::OPC_BRANCH, pkg_config::OPC_JALR,
      pkg_config::OPC_JAL, pkg_config::OPC_SYSTEM: opc_known = 1'b1;
      default: opc_known = 1'b0;
    endcase
  end

  always_comb begin
    d_illegal = 1'b0;
    if (!opc_known || (instr_i[1:0] != 2'b11)) begin
      d_illegal = 1'b1;
    end else if (opcode == pkg_config::OPC_OP) begin
      if (funct7 == 7'b0100000)
        d_illegal = (funct3 != 3'b000) && (funct3 != 3'b101);
      else
        d_illegal = (funct7 != 7'b0000000);
    end else if (opcode == pkg_config::OPC_OP_IMM) begin
      if (funct3 == 3'b001)
        d_illegal = (funct7 != 7'b0000000);
      else if (funct3 == 3'b101)
        d_illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
    end
  end
`else
  assign d_illegal = 1'b0;
`endif

  always_comb begin
    d_alu_op = pkg_config::OP_ALU_ADD;
    d_a_sel  = 2'd0;
    d_b_sel  = 1'b1;
    d_imm32  = 32'd0;
    d_rd_we  = 1'b0;
    d_is_alu = 1'b0;
    case (opcode)
      pkg_config::OPC_OP: begin
        d_alu_op = alu_from_funct3(funct3, alt);
        d_b_sel  = 1'b0;
        d_rd_we  = 1'b1;
        d_is_alu = 1'b1;
      end
      pkg_config::OPC_OP_IMM: begin
        d_alu_op = alu_from_funct3(funct3, alt && (funct3 == 3'b101));
        d_imm32  = imm_i;
        d_rd_we  = 1'b1;
        d_is_alu = 1'b1;
      end
      pkg_config::OPC_LUI: begin
        d_a_sel  = 2'd2;
        d_imm32  = imm_u;
        d_rd_we  = 1'b1;
        d_is_alu = 1'b1;
      end
      pkg_config::OPC_AUIPC: begin
        d_a_sel  = 2'd1;
        d_imm32  = imm_u;
        d_rd_we  = 1'b1;
        d_is_alu = 1'b1;
      end
      pkg_config::OPC_LOAD: begin
        d_imm32 = imm_i;
        d_rd_we = 1'b1;
      end
      pkg_config::OPC_JALR: begin
        d_imm32 = imm_i;
        d_rd_we = 1'b1;
      end
      pkg_config::OPC_JAL: begin
        d_imm32 = imm_j;
        d_rd_we = 1'b1;
      end
      pkg_config::OPC_STORE:  d_imm32 = imm_s;
      pkg_config::OPC_BRANCH: d_imm32 = imm_b;
      pkg_config::OPC_FENCE,
      pkg_config::OPC_SYSTEM: d_imm32 = imm_i;
      default: ;
    endcase
    // Illegal encodings must not look like ALU work or commit a register.
    if (d_illegal) begin
      d_alu_op = pkg_config::OP_ALU_ADD;
      d_rd_we  = 1'b0;
      d_is_alu = 1'b0;
    end
    if (rd == 5'd0) d_rd_we = 1'b0;
  end

  assign d_imm      = DATA_WIDTH'(signed'(d_imm32));
  assign in_ready_o = !out_valid_o || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;

  // Priority: reset, then flush, then accept, then plain consume.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      alu_op_o    <= pkg_config::OP_ALU_ADD;
      a_sel_o     <= 2'd0;
      b_sel_o     <= 1'b0;
      imm_o       <= '0;
      rs1_addr_o  <= 5'd0;
      rs2_addr_o  <= 5'd0;
      rd_addr_o   <= 5'd0;
      rd_we_o     <= 1'b0;
      is_alu_o    <= 1'b0;
      pc_o        <= '0;
      illegal_o   <= 1'b0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      alu_op_o    <= d_alu_op;
      a_sel_o     <= d_a_sel;
      b_sel_o     <= d_b_sel;
      imm_o       <= d_imm;
      rs1_addr_o  <= instr_i[19:15];
      rs2_addr_o  <= instr_i[24:20];
      rd_addr_o   <= rd;
      rd_we_o     <= d_rd_we;
      is_alu_o    <= d_is_alu;
      pc_o        <= pc_i;
      illegal_o   <= d_illegal;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: spec-level decode model plus directed literal checks.
// Expectations for illegal_o follow DECODE_ILLEGAL_CHECK_EN when it is defined for the build.

module tb_decode_stage;
  import pkg_config::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [5:0]  alu_op_o;
  logic [1:0]  a_sel_o;
  logic        b_sel_o;
  logic [31:0] imm_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic        rd_we_o, is_alu_o, illegal_o;
  logic [31:0] pc_o;

  int checks = 0;
  int failures = 0;

  decode_stage dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .flush_i(flush_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .alu_op_o(alu_op_o), .a_sel_o(a_sel_o), .b_sel_o(b_sel_o),
    .imm_o(imm_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
    .rd_we_o(rd_we_o), .is_alu_o(is_alu_o), .pc_o(pc_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [5:0]  op;
    logic [1:0]  a;
    logic        b;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        we, alu, ill;
    logic [31:0] pc;
    bit          sel_care, imm_care;
  } dec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Decoded fields straight from the RV32I field definitions, immediates as signed arithmetic.
  function automatic dec_t model(input logic [31:0] w, input logic [31:0] pc);
    dec_t d;
    logic [5:0] by_f3 [8];
    int i_imm, s_imm, b_imm, j_imm;
    bit unknown;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = w[14:12];
    f7 = w[31:25];
    by_f3 = '{OP_ALU_ADD, OP_ALU_SLL, OP_ALU_SLT, OP_ALU_SLTU,
              OP_ALU_XOR, OP_ALU_SRL, OP_ALU_OR, OP_ALU_AND};
    i_imm = int'(w[31:20]) - (w[31] ? 4096 : 0);
    s_imm = int'(w[31:25]) * 32 + int'(w[11:7]) - (w[31] ? 4096 : 0);
    b_imm = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2 - (w[31] ? 4096 : 0);
    j_imm = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2
            - (w[31] ? (1 << 20) : 0);
    d.op = OP_ALU_ADD; d.a = 2'd0; d.b = 1'b1; d.imm = 32'd0;
    d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.rd = w[11:7];
    d.we = 1'b0; d.alu = 1'b0; d.ill = 1'b0; d.pc = pc;
    d.sel_care = 1'b1; d.imm_care = 1'b1;
    unknown = 1'b0;
    case (w[6:0])
      7'h33: begin
        d.alu = 1; d.we = 1; d.b = 0; d.imm_care = 0;
        if (f3 == 3'd0 && w[30]) d.op = OP_ALU_SUB;
        else if (f3 == 3'd5 && w[30]) d.op = OP_ALU_SRA;
        else d.op = by_f3[f3];
      end
      7'h13: begin
        d.alu = 1; d.we = 1; d.imm = 32'(i_imm);
        d.op = (f3 == 3'd5 && w[30]) ? OP_ALU_SRA : by_f3[f3];
      end
      7'h37: begin d.alu = 1; d.we = 1; d.a = 2; d.imm = w & 32'hFFFF_F000; end
      7'h17: begin d.alu = 1; d.we = 1; d.a = 1; d.imm = w & 32'hFFFF_F000; end
      7'h03, 7'h67: begin d.we = 1; d.imm = 32'(i_imm); end
      7'h0F, 7'h73: d.imm = 32'(i_imm);
      7'h23: d.imm = 32'(s_imm);
      7'h63: d.imm = 32'(b_imm);
      7'h6F: begin d.we = 1; d.imm = 32'(j_imm); end
      default: begin unknown = 1'b1; d.sel_care = 0; d.imm_care = 0; end
    endcase
`ifdef DECODE_ILLEGAL_CHECK_EN
    d.ill = unknown || (w[1:0] != 2'b11);
    if (w[6:0] == 7'h33)
      d.ill = d.ill || !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
    if (w[6:0] == 7'h13 && f3 == 3'd1) d.ill = d.ill || (f7 != 7'h00);
    if (w[6:0] == 7'h13 && f3 == 3'd5) d.ill = d.ill || !(f7 == 7'h00 || f7 == 7'h20);
    if (d.ill) begin d.we = 0; d.alu = 0; d.op = OP_ALU_ADD; end
`else
    if (unknown || f7 == 7'h7F) d.ill = 1'b0;
`endif
    if (d.rd == 5'd0) d.we = 1'b0;
    return d;
  endfunction

  // Register-level behaviour of the stage, tracked on every rising edge.
  dec_t exp_d;
  bit   exp_valid = 1'b0;
  bit   exp_fresh = 1'b0;
  bit   armed = 1'b0;

  always @(posedge clk_i) begin
    bit rdy;
    rdy = !exp_valid || out_ready_i;
    armed = 1'b1;
    if (!rst_ni) begin
      exp_valid = 0; exp_fresh = 1;
      exp_d = model(32'h0000_0013, 32'd0);
      exp_d.imm = 0; exp_d.rs1 = 0; exp_d.rs2 = 0; exp_d.rd = 0; exp_d.we = 0;
      exp_d.alu = 0; exp_d.b = 0; exp_d.ill = 0; exp_d.pc = 0;
    end else if (flush_i) begin
      exp_valid = 0;
    end else if (in_valid_i && rdy) begin
      exp_valid = 1; exp_fresh = 0;
      exp_d = model(instr_i, pc_i);
    end else if (out_ready_i) begin
      exp_valid = 0;
    end
  end

  always @(negedge clk_i) begin
    if (armed) begin
      check("m_out_valid", out_valid_o, exp_valid);
      check("m_in_ready", in_ready_o, !exp_valid || out_ready_i);
      if (exp_valid || exp_fresh) begin
        check("m_alu_op", alu_op_o, exp_d.op);
        check("m_rs1", rs1_addr_o, exp_d.rs1);
        check("m_rs2", rs2_addr_o, exp_d.rs2);
        check("m_rd", rd_addr_o, exp_d.rd);
        check("m_rd_we", rd_we_o, exp_d.we);
        check("m_is_alu", is_alu_o, exp_d.alu);
        check("m_illegal", illegal_o, exp_d.ill);
        check("m_pc", pc_o, exp_d.pc);
        if (exp_d.sel_care) begin
          check("m_a_sel", a_sel_o, exp_d.a);
          check("m_b_sel", b_sel_o, exp_d.b);
        end
        if (exp_d.imm_care) check("m_imm", imm_o, exp_d.imm);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  logic [31:0] vecs [22] = '{
    32'h0000A103, 32'hFE20AE23, 32'hFE0008E3, 32'h008000EF, 32'h000080E7, 32'h00311093,
    32'h0020C1B3, 32'h0020F1B3, 32'h0020E1B3, 32'h0020B1B3, 32'h0020A1B3, 32'h0020D1B3,
    32'h4020D1B3, 32'h00209133, 32'h00000073, 32'h00000033, 32'hFFF00013, 32'h0000000F,
    32'h800002B7, 32'h0220D1B3, 32'h40311093, 32'h80000A6F
  };

  initial begin
    bit exp_ill0;
    int idx;
    bit go;
    rst_ni = 0; in_valid_i = 0; out_ready_i = 1; flush_i = 0; instr_i = 0; pc_i = 0;
    step(); step();
    check("rst_out_valid", out_valid_o, 0);
    check("rst_in_ready", in_ready_o, 1);
    check("rst_imm", imm_o, 0);
    check("rst_alu_op", alu_op_o, OP_ALU_ADD);
    rst_ni = 1;

    instr_i = 32'h00500093; pc_i = 32'h100; in_valid_i = 1;
    step();
    in_valid_i = 0;
    check("addi_valid", out_valid_o, 1);
    check("addi_alu_op", alu_op_o, OP_ALU_ADD);
    check("addi_a_sel", a_sel_o, 0);
    check("addi_b_sel", b_sel_o, 1);
    check("addi_imm", imm_o, 5);
    check("addi_rd", rd_addr_o, 1);
    check("addi_rd_we", rd_we_o, 1);
    check("addi_is_alu", is_alu_o, 1);
    check("addi_pc", pc_o, 32'h100);
    step();
    check("consume_drop", out_valid_o, 0);

    instr_i = 32'h402081B3; pc_i = 32'h104; in_valid_i = 1;
    step();
    check("sub_alu_op", alu_op_o, OP_ALU_SUB);
    check("sub_rs1", rs1_addr_o, 1);
    check("sub_rs2", rs2_addr_o, 2);
    check("sub_b_sel", b_sel_o, 0);
    check("sub_in_ready", in_ready_o, 1);
    instr_i = 32'h40335293; pc_i = 32'h108;
    step();
    in_valid_i = 0;
    check("srai_valid", out_valid_o, 1);
    check("srai_alu_op", alu_op_o, OP_ALU_SRA);
    check("srai_shamt", {27'd0, imm_o[4:0]}, 3);
    check("srai_b_sel", b_sel_o, 1);
    check("srai_in_ready", in_ready_o, 1);
    step();

    instr_i = 32'h123453B7; pc_i = 32'h10C; in_valid_i = 1; out_ready_i = 0;
    step();
    instr_i = 32'h00500093; pc_i = 32'h110;
    for (int k = 0; k < 3; k++) begin
      check("lui_valid", out_valid_o, 1);
      check("lui_imm", imm_o, 32'h12345000);
      check("lui_a_sel", a_sel_o, 2);
      check("lui_pc", pc_o, 32'h10C);
      check("lui_in_ready", in_ready_o, 0);
      step();
    end
    in_valid_i = 0; out_ready_i = 1;
    #1;
    check("lui_release_ready", in_ready_o, 1);
    step();

    instr_i = 32'h00001517; pc_i = 32'h200; in_valid_i = 1; out_ready_i = 0;
    step();
    check("auipc_imm", imm_o, 32'h1000);
    check("auipc_a_sel", a_sel_o, 1);
    flush_i = 1; instr_i = 32'h00500093; pc_i = 32'h300; out_ready_i = 1;
    step();
    flush_i = 0; in_valid_i = 0;
    check("flush_valid", out_valid_o, 0);
    step();
    check("flush_no_ghost", out_valid_o, 0);

    instr_i = 32'h00000000; pc_i = 32'h400; in_valid_i = 1;
    step();
    in_valid_i = 0;
`ifdef DECODE_ILLEGAL_CHECK_EN
    exp_ill0 = 1'b1;
`else
    exp_ill0 = 1'b0;
`endif
    check("zero_illegal", illegal_o, exp_ill0);
    check("zero_rd_we", rd_we_o, 0);
    step();

    idx = 0;
    for (int c = 0; c < 300 && idx < 22; c++) begin
      instr_i = vecs[idx]; pc_i = 32'h1000 + 4 * idx;
      in_valid_i = (c % 5 != 4);
      out_ready_i = (c % 3 != 2);
      #1;
      go = in_valid_i && in_ready_o;
      step();
      if (go) idx++;
    end
    check("vec_all_accepted", idx, 22);
    in_valid_i = 0; out_ready_i = 1;
    step();

    instr_i = 32'h123453B7; pc_i = 32'h500; in_valid_i = 1; out_ready_i = 0;
    step();
    rst_ni = 0; flush_i = 1;
    step();
    rst_ni = 1; flush_i = 0; in_valid_i = 0;
    check("rst_stall_valid", out_valid_o, 0);
    check("rst_stall_imm", imm_o, 0);
    check("rst_stall_a_sel", a_sel_o, 0);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
